// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave: default word length, FSM encoding and
// synchronizer depth.
package spi_pkg;
    localparam int SPI_M_DEFAULT = 16;
    localparam int SYNC_DEPTH    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_TX = 2'd1,
        SHIFT   = 2'd2
    } spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with one extra stage for rise/fall detection.
// Every flop clears to 0. A frame already in progress at reset therefore never
// shows a LOAD fall, and the slave waits for the next one.
module spi_sync_edge
    import spi_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic                  prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_DEPTH-2:0], d};
        prev_d = sync_q[SYNC_DEPTH-1];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[SYNC_DEPTH-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_DEPTH-1] & prev_q;
endmodule

// File: rtl/spi_slave.sv
// Oversampled SPI mode-0 slave: all SPI pins are sampled in the clk domain.
// Optional overrun flag (port ovr) is enabled with `define SPI_SLAVE_OVERRUN_EN.
module spi_slave
    import spi_pkg::*;
#(
    parameter int M = SPI_M_DEFAULT
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         SCLK,
    input  logic         LOAD,
    input  logic         MOSI,
    output logic         MISO,
    input  logic [M-1:0] DI,
    input  logic         rd,
    output logic [M-1:0] DO,
    output logic         rx_vld,
    output logic         busy,
    output logic [7:0]   cb_bit
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    output logic         ovr
`endif
);
    logic sclk_rise, sclk_fall, load_rise, load_fall;

    spi_sync_edge u_sclk (.clk(clk), .clr(clr), .d(SCLK), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge u_load (.clk(clk), .clr(clr), .d(LOAD), .rise(load_rise), .fall(load_fall));

    // MOSI is delayed by the same depth as SCLK so data and edge line up.
    logic [SYNC_DEPTH-1:0] mosi_q, mosi_d;
    logic                  mosi_s;
    assign mosi_d = {mosi_q[SYNC_DEPTH-2:0], MOSI};
    assign mosi_s = mosi_q[SYNC_DEPTH-1];

    spi_state_e   state_q, state_d;
    logic [M-1:0] sr_tx_q, sr_tx_d, sr_rx_q, sr_rx_d, do_q, do_d, rx_next;
    logic [7:0]   cb_q, cb_d;
    logic         vld_q, vld_d, reload_q, reload_d, done;

    always_comb begin
        state_d  = state_q;
        sr_tx_d  = sr_tx_q;
        sr_rx_d  = sr_rx_q;
        do_d     = do_q;
        cb_d     = cb_q;
        reload_d = reload_q;
        done     = 1'b0;
        rx_next  = {sr_rx_q[M-2:0], mosi_s};
        case (state_q)
            IDLE: begin
                cb_d     = '0;
                reload_d = 1'b0;
                if (load_fall) state_d = LOAD_TX;
            end
            LOAD_TX: begin
                sr_tx_d  = DI;
                sr_rx_d  = '0;
                cb_d     = '0;
                reload_d = 1'b0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                if (sclk_rise) begin
                    sr_rx_d = rx_next;
                    if (cb_q == 8'(M - 1)) begin
                        done     = 1'b1;
                        do_d     = rx_next;
                        cb_d     = '0;
                        reload_d = 1'b1;
                    end else begin
                        cb_d = cb_q + 8'd1;
                    end
                end
                // After a word boundary the next fall presents a fresh DI instead of shifting.
                if (sclk_fall) begin
                    if (reload_q) begin
                        sr_tx_d  = DI;
                        reload_d = 1'b0;
                    end else begin
                        sr_tx_d = sr_tx_q << 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_rise) begin
            state_d = IDLE;
            cb_d    = '0;
        end
        vld_d = done ? 1'b1 : (rd ? 1'b0 : vld_q);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            sr_tx_q  <= '0;
            sr_rx_q  <= '0;
            do_q     <= '0;
            cb_q     <= '0;
            vld_q    <= 1'b0;
            reload_q <= 1'b0;
            mosi_q   <= '0;
        end else begin
            state_q  <= state_d;
            sr_tx_q  <= sr_tx_d;
            sr_rx_q  <= sr_rx_d;
            do_q     <= do_d;
            cb_q     <= cb_d;
            vld_q    <= vld_d;
            reload_q <= reload_d;
            mosi_q   <= mosi_d;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic ovr_q, ovr_d;
    // A completion in the same clk as rd is a normal handoff, not an overrun.
    assign ovr_d = (done && vld_q && !rd) ? 1'b1 : (rd ? 1'b0 : ovr_q);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) ovr_q <= 1'b0;
        else     ovr_q <= ovr_d;
    end

    assign ovr = ovr_q;
`endif

    assign MISO   = (state_q == SHIFT) & sr_tx_q[M-1];
    assign busy   = (state_q != IDLE);
    assign cb_bit = cb_q;
    assign DO     = do_q;
    assign rx_vld = vld_q;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave (M=16): the bench acts as an SPI mode-0 master
// with SCLK at 1/16 of clk.
module tb_spi_slave;
    logic        clk = 1'b0;
    logic        clr, SCLK, LOAD, MOSI, rd;
    logic        MISO, rx_vld, busy;
    logic [15:0] DI, DO;
    logic [7:0]  cb_bit;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic        ovr;
`endif

    int tests = 0;
    int fails = 0;
    logic [15:0] rx, rx2;

    always #5 clk = ~clk;

    spi_slave #(.M(16)) dut (
        .clk(clk), .clr(clr), .SCLK(SCLK), .LOAD(LOAD), .MOSI(MOSI), .MISO(MISO),
        .DI(DI), .rd(rd), .DO(DO), .rx_vld(rx_vld), .busy(busy), .cb_bit(cb_bit)
`ifdef SPI_SLAVE_OVERRUN_EN
        , .ovr(ovr)
`endif
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send the top nb bits of tx; di_after is applied after the last rise, and
    // rd_end pulses rd in the same clk as the slave completes the word.
    task automatic xfer(input logic [15:0] tx, input int nb, input logic [15:0] di_after,
                        input bit rd_end, output logic [15:0] rxw);
        rxw = '0;
        for (int i = 15; i > 15 - nb; i--) begin
            MOSI   = tx[i];
            rxw[i] = MISO;
            SCLK   = 1'b1;
            if (i == 15 - nb + 1) begin
                DI = di_after;
                if (rd_end) begin
                    tick(2); rd = 1'b1; tick(1); rd = 1'b0; tick(5);
                end else begin
                    tick(8);
                end
            end else begin
                tick(8);
            end
            SCLK = 1'b0;
            tick(8);
        end
    endtask

    task automatic pulse_rd();
        rd = 1'b1; tick(1); rd = 1'b0;
    endtask

    initial begin
        clr = 1'b1; LOAD = 1'b1; SCLK = 1'b0; MOSI = 1'b0; DI = '0; rd = 1'b0;
        tick(3);
        chk("rst_miso", MISO, 0);
        chk("rst_do", DO, 0);
        chk("rst_vld", rx_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cb", cb_bit, 0);
`ifdef SPI_SLAVE_OVERRUN_EN
        chk("rst_ovr", ovr, 0);
`endif
        clr = 1'b0;
        tick(4);

        // Single frame with busy/MISO latency from LOAD fall
        DI = 16'hBC5A;
        LOAD = 1'b0;
        tick(2); chk("busy_lat2", busy, 0);
        tick(1); chk("busy_lat3", busy, 1); chk("miso_lat3", MISO, 0);
        tick(1); chk("miso_lat4", MISO, 1);
        tick(4);
        xfer(16'hA5C3, 16, 16'hBC5A, 0, rx);
        chk("single_rx", rx, 16'hBC5A);
        chk("single_do", DO, 16'hA5C3);
        chk("single_vld", rx_vld, 1);
        chk("single_cb", cb_bit, 0);
        LOAD = 1'b1; tick(8);
        chk("single_idle", busy, 0);

        tick(5); pulse_rd();
        chk("rd_clear", rx_vld, 0);

        // Back-to-back words, DI changed before the word boundary reload
        DI = 16'h3C5A;
        LOAD = 1'b0; tick(8);
        xfer(16'h0001, 16, 16'h1234, 0, rx);
        chk("b2b_rx1", rx, 16'h3C5A);
        chk("b2b_do1", DO, 16'h0001);
        chk("b2b_vld1", rx_vld, 1);
        pulse_rd(); tick(2);
        chk("b2b_vld_clr", rx_vld, 0);
        xfer(16'hFFFE, 16, 16'h1234, 0, rx2);
        chk("b2b_rx2", rx2, 16'h1234);
        chk("b2b_do2", DO, 16'hFFFE);
        chk("b2b_vld2", rx_vld, 1);
        LOAD = 1'b1; tick(8);

        // rd coincident with completion: completion wins
        pulse_rd();
        chk("coin_pre", rx_vld, 0);
        DI = 16'h0F0F;
        LOAD = 1'b0; tick(8);
        xfer(16'h00FF, 16, 16'h0F0F, 1, rx);
        chk("coin_rx", rx, 16'h0F0F);
        chk("coin_do", DO, 16'h00FF);
        chk("coin_vld", rx_vld, 1);
`ifdef SPI_SLAVE_OVERRUN_EN
        chk("coin_ovr", ovr, 0);
`endif
        LOAD = 1'b1; tick(8);

        // Two words without rd
        pulse_rd();
        LOAD = 1'b0; tick(8);
        xfer(16'h1111, 16, 16'h0F0F, 0, rx);
`ifdef SPI_SLAVE_OVERRUN_EN
        chk("ovr_first", ovr, 0);
`endif
        xfer(16'h2222, 16, 16'h0F0F, 0, rx);
        chk("ovr_do", DO, 16'h2222);
        chk("ovr_vld", rx_vld, 1);
`ifdef SPI_SLAVE_OVERRUN_EN
        chk("ovr_set", ovr, 1);
`endif
        LOAD = 1'b1; tick(8);
        pulse_rd();
`ifdef SPI_SLAVE_OVERRUN_EN
        chk("ovr_clr", ovr, 0);
`endif

        // Aborted frame after 7 SCLK
        LOAD = 1'b0; tick(8);
        xfer(16'hF0F0, 7, 16'h0F0F, 0, rx);
        chk("abort_cb7", cb_bit, 7);
        LOAD = 1'b1; tick(8);
        chk("abort_cb", cb_bit, 0);
        chk("abort_busy", busy, 0);
        chk("abort_vld", rx_vld, 0);
        chk("abort_do", DO, 16'h2222);
        DI = 16'h9ABC;
        LOAD = 1'b0; tick(8);
        xfer(16'h6C39, 16, 16'h9ABC, 0, rx);
        chk("after_abort_rx", rx, 16'h9ABC);
        chk("after_abort_do", DO, 16'h6C39);
        LOAD = 1'b1; tick(8);

        // clr at bit 9: slave must not rejoin until the next LOAD fall
        LOAD = 1'b0; tick(8);
        xfer(16'hAAAA, 9, 16'h9ABC, 0, rx);
        chk("clr_cb9", cb_bit, 9);
        clr = 1'b1; tick(1);
        chk("clr_do", DO, 0);
        chk("clr_vld", rx_vld, 0);
        chk("clr_busy", busy, 0);
        chk("clr_cb", cb_bit, 0);
        chk("clr_miso", MISO, 0);
        clr = 1'b0;
        xfer(16'hAAAA, 7, 16'h9ABC, 0, rx);
        chk("clr_no_rejoin_busy", busy, 0);
        chk("clr_no_rejoin_vld", rx_vld, 0);
        LOAD = 1'b1; tick(8);
        DI = 16'h5555;
        LOAD = 1'b0; tick(8);
        xfer(16'h8001, 16, 16'h5555, 0, rx);
        chk("restart_rx", rx, 16'h5555);
        chk("restart_do", DO, 16'h8001);
        chk("restart_vld", rx_vld, 1);
        LOAD = 1'b1; tick(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
